// File: rtl/qos_egress_sched_pkg.sv
// qos_egress_sched_pkg: shared FSM encoding, port count and default widths/weights.
package qos_egress_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, CAP = 2'd2, OUT = 2'd3} state_e;
  localparam int PORTS      = 4;
  localparam int DATA_W_DEF = 12;
  localparam int WEIGHT_W_DEF = 4;
  localparam int W0_DEF = 4;
  localparam int W1_DEF = 3;
  localparam int W2_DEF = 2;
  localparam int W3_DEF = 1;
  function automatic int wmax1(input int w);
    return (w == 0) ? 1 : w;
  endfunction
endpackage

// File: rtl/qos_egress_sched_qos_wrr_pick.sv
// qos_wrr_pick: keep ptr while it has data and credit, else first non-empty port after ptr (wrapping to ptr).
module qos_wrr_pick (
  input  logic [1:0] ptr,
  input  logic [3:0] empty,
  input  logic [3:0] cred_zero,
  output logic [1:0] sel,
  output logic       reload
);
  always_comb begin
    sel = ptr;
    reload = 1'b0;
    if (empty[ptr] || cred_zero[ptr]) begin
      reload = 1'b1;
      for (int i = 4; i >= 1; i--)
        if (!empty[ptr + 2'(i)]) sel = ptr + 2'(i);
    end
  end
endmodule

// File: rtl/qos_egress_sched.sv
// qos_egress_sched: weighted round-robin drain of four output FIFOs onto one valid/ready stream.
// Define QOS_EGRESS_STATS_EN to add per-port saturating egress counters (stat_idx/stat_count).
module qos_egress_sched
  import qos_egress_sched_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int W0       = W0_DEF,
  parameter int W1       = W1_DEF,
  parameter int W2       = W2_DEF,
  parameter int W3       = W3_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] fifo_dataout0,
  input  logic [DATA_W-1:0] fifo_dataout1,
  input  logic [DATA_W-1:0] fifo_dataout2,
  input  logic [DATA_W-1:0] fifo_dataout3,
  output logic [3:0]        pop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_port
`ifdef QOS_EGRESS_STATS_EN
  ,
  input  logic [1:0]        stat_idx,
  output logic [7:0]        stat_count
`endif
);
  localparam logic [PORTS-1:0][WEIGHT_W-1:0] RLD = {WEIGHT_W'(wmax1(W3)), WEIGHT_W'(wmax1(W2)),
                                                    WEIGHT_W'(wmax1(W1)), WEIGHT_W'(wmax1(W0))};
  state_e state_q, state_d;
  logic [1:0] ptr_q, ptr_d, port_q, port_d, sel;
  logic [PORTS-1:0][WEIGHT_W-1:0] cred_q, cred_d;
  logic [DATA_W-1:0] data_q, data_d, fifo_mux;
  logic [3:0] cred_zero;
  logic reload, elig, hs, go;
  always_comb
    for (int i = 0; i < PORTS; i++) cred_zero[i] = (cred_q[i] == '0);
  qos_wrr_pick u_pick (.ptr(ptr_q), .empty(empty), .cred_zero(cred_zero), .sel(sel), .reload(reload));
  assign elig = enable && !(&empty);
  assign hs = (state_q == OUT) && out_ready;
  assign go = elig && ((state_q == IDLE) || hs);
  assign fifo_mux = (ptr_q == 2'd0) ? fifo_dataout0 : (ptr_q == 2'd1) ? fifo_dataout1 :
                    (ptr_q == 2'd2) ? fifo_dataout2 : fifo_dataout3;
  assign pop = (state_q == RD) ? (4'b0001 << ptr_q) : 4'b0000;
  assign out_valid = (state_q == OUT);
  assign out_data = data_q;
  assign out_port = port_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cred_d = cred_q;
    data_d = data_q;
    port_d = port_q;
    if (go) begin
      state_d = RD;
      ptr_d = sel;
      if (reload) cred_d[sel] = RLD[sel];
    end else if (hs) state_d = IDLE;
    if (state_q == RD) begin
      state_d = CAP;
      cred_d[ptr_q] = cred_q[ptr_q] - WEIGHT_W'(cred_q[ptr_q] != '0);
    end
    if (state_q == CAP) begin
      state_d = OUT;
      data_d = fifo_mux;
      port_d = ptr_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cred_q <= RLD;
      data_q <= '0;
      port_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cred_q <= cred_d;
      data_q <= data_d;
      port_q <= port_d;
    end
`ifdef QOS_EGRESS_STATS_EN
  logic [PORTS-1:0][7:0] stat_q, stat_d;
  always_comb begin
    stat_d = stat_q;
    if (hs && stat_q[port_q] != 8'hFF) stat_d[port_q] = stat_q[port_q] + 8'd1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) stat_q <= '0;
    else stat_q <= stat_d;
  assign stat_count = stat_q[stat_idx];
`endif
endmodule
